scaler_sequencer: RTL and testbench

Command-level controller in front of the image-scaling engine (replication / decimation / nearest-neighbour / average). It accepts one scaling command at a time through a valid/ready handshake and can optionally blank the frame RAM first. It drives the engine's algorithm selector, zoom switch and decoding enable so every run starts from a forced engine reset. It owns the frame-RAM write port, muxing the clear writer and the engine, and reports done, error and run-length status to the host/UI logic.

---
 rtl/scaler_sequencer_if.sv | 27 ++
 rtl/scaler_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_scaler_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_sequencer_if.sv
// Command handshake bundle between the host/UI logic and scaler_sequencer.
// Ports: cmd_valid/cmd_ready handshake plus cmd_alg, cmd_zoom, cmd_clear payload.
interface scaler_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_alg;
    logic       cmd_zoom;
    logic       cmd_clear;

    // Host side: issues commands, watches ready.
    modport master (
        output cmd_valid,
        output cmd_alg,
        output cmd_zoom,
        output cmd_clear,
        input  cmd_ready
    );

    // Sequencer side: accepts commands.
    modport slave (
        input  cmd_valid,
        input  cmd_alg,
        input  cmd_zoom,
        input  cmd_clear,
        output cmd_ready
    );
endinterface

// File: rtl/scaler_sequencer.sv
// Command-level controller for the image-scaling engine: optional frame-RAM
// clear, forced engine reset (FLUSH), selector settle, RUN with timeout.
// Ports: clk, reset (async, active-high); cmd (slave handshake bundle);
//   abort; eng_seletor/eng_sw/eng_decoding to the engine; eng_done and
//   eng_ram_* from the engine; ram_* frame-RAM write port; busy,
//   done_pulse, error, err_code, run_cycles status to the host.
module scaler_sequencer #(
    parameter int          ADDR_W         = 19,
    parameter int          FRAME_PIXELS   = 307200,
    parameter logic [7:0]  CLEAR_VALUE    = 8'h00,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    scaler_sequencer_if.slave cmd,
    input  logic              abort,
    output logic [2:0]        eng_seletor,
    output logic              eng_sw,
    output logic              eng_decoding,
    input  logic              eng_done,
    input  logic [ADDR_W-1:0] eng_ram_wraddr,
    input  logic [7:0]        eng_ram_data,
    input  logic              eng_ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done_pulse,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       run_cycles
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0]       RUN_LIMIT   = 32'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FLUSH,
        S_SETTLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] clr_cnt_q;
    logic [SET_W-1:0]  set_cnt_q;
    logic [31:0]       run_cnt_q;
    logic [2:0]        alg_q;
    logic              zoom_q;
    logic [2:0]        sel_q;
    logic              sw_q;
    logic              error_q;
    logic [1:0]        code_q;
    logic [31:0]       rc_q;
    logic              dp_q;

    logic accept;
    logic legal;
    logic is_busy;
    logic hold_sel;
    logic run_done;
    logic run_tmo;

    // Command acceptance and legality of the offered algorithm.
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign legal  = (cmd.cmd_alg != 3'd0) && (cmd.cmd_alg <= 3'd4);

    assign is_busy = (state_q == S_CLEAR)  || (state_q == S_FLUSH) ||
                     (state_q == S_SETTLE) || (state_q == S_RUN);

    // Next-state logic. Abort overrides every other exit of a busy state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept) begin
                    if (!legal)
                        state_d = S_ERR;
                    else if (cmd.cmd_clear)
                        state_d = S_CLEAR;
                    else
                        state_d = S_FLUSH;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR)
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (set_cnt_q == SETTLE_LAST)
                    state_d = S_RUN;
            end
            S_RUN: begin
                // Completion beats timeout when both land together.
                if (eng_done)
                    state_d = S_DONE;
                else if (run_cnt_q == RUN_LIMIT)
                    state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (is_busy && abort)
            state_d = S_IDLE;
    end

    assign run_done = (state_q == S_RUN) && (state_d == S_DONE);
    assign run_tmo  = (state_q == S_RUN) && (state_d == S_ERR);

    // Engine selector/zoom are live from SETTLE through DONE only; forcing
    // them to 0 in FLUSH makes the engine see a change even on repeats.
    assign hold_sel = (state_d == S_SETTLE) || (state_d == S_RUN) ||
                      (state_d == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            set_cnt_q <= '0;
            run_cnt_q <= 32'd1;
            alg_q     <= 3'd0;
            zoom_q    <= 1'b0;
            sel_q     <= 3'd0;
            sw_q      <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            rc_q      <= 32'd0;
            dp_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            dp_q    <= run_done;

            if (state_q == S_CLEAR)
                clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            else
                clr_cnt_q <= '0;

            if (state_q == S_SETTLE)
                set_cnt_q <= set_cnt_q + SET_W'(1);
            else
                set_cnt_q <= '0;

            // Preloaded to 1 so the first RUN cycle counts as cycle 1.
            if (state_q == S_RUN)
                run_cnt_q <= run_cnt_q + 32'd1;
            else
                run_cnt_q <= 32'd1;

            if (hold_sel) begin
                sel_q <= alg_q;
                sw_q  <= zoom_q;
            end else begin
                sel_q <= 3'd0;
                sw_q  <= 1'b0;
            end

            if (accept) begin
                alg_q   <= cmd.cmd_alg;
                zoom_q  <= cmd.cmd_zoom;
                rc_q    <= 32'd0;
                error_q <= !legal;
                code_q  <= legal ? ERR_NONE : ERR_ILLEGAL;
            end

            if (run_done)
                rc_q <= run_cnt_q;

            if (run_tmo) begin
                rc_q    <= run_cnt_q;
                error_q <= 1'b1;
                code_q  <= ERR_TIMEOUT;
            end
        end
    end

    // Frame-RAM write port: clear writer in CLEAR, engine in RUN.
    always_comb begin
        ram_wren   = 1'b0;
        ram_wraddr = '0;
        ram_data   = 8'h00;
        if (state_q == S_CLEAR) begin
            ram_wren   = 1'b1;
            ram_wraddr = clr_cnt_q;
            ram_data   = CLEAR_VALUE;
        end else if (state_q == S_RUN) begin
            ram_wren   = eng_ram_wren;
            ram_wraddr = eng_ram_wraddr;
            ram_data   = eng_ram_data;
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE) ||
                           (state_q == S_ERR);

    assign busy         = is_busy;
    assign eng_decoding = (state_q == S_RUN);
    assign eng_seletor  = sel_q;
    assign eng_sw       = sw_q;
    assign done_pulse   = dp_q;
    assign error        = error_q;
    assign err_code     = code_q;
    assign run_cycles   = rc_q;

endmodule

// File: tb/tb_scaler_sequencer.sv
// Self-checking bench for scaler_sequencer: command table, hand-written
// corner sequences and randomized commands against a cycle-timeline model.
module tb_scaler_sequencer;

    localparam int AW = 19;
    localparam int FP = 16;
    localparam int ST = 2;
    localparam int TO = 600;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scaler_sequencer_if cmd_if ();

    logic          abort;
    logic [2:0]    eng_seletor;
    logic          eng_sw;
    logic          eng_decoding;
    logic          eng_done;
    logic [AW-1:0] eng_ram_wraddr;
    logic [7:0]    eng_ram_data;
    logic          eng_ram_wren;
    logic [AW-1:0] ram_wraddr;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic          busy;
    logic          done_pulse;
    logic          error;
    logic [1:0]    err_code;
    logic [31:0]   run_cycles;

    scaler_sequencer #(
        .ADDR_W         (AW),
        .FRAME_PIXELS   (FP),
        .CLEAR_VALUE    (8'h00),
        .SETTLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd_if),
        .abort          (abort),
        .eng_seletor    (eng_seletor),
        .eng_sw         (eng_sw),
        .eng_decoding   (eng_decoding),
        .eng_done       (eng_done),
        .eng_ram_wraddr (eng_ram_wraddr),
        .eng_ram_data   (eng_ram_data),
        .eng_ram_wren   (eng_ram_wren),
        .ram_wraddr     (ram_wraddr),
        .ram_data       (ram_data),
        .ram_wren       (ram_wren),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .error          (error),
        .err_code       (err_code),
        .run_cycles     (run_cycles)
    );

    typedef struct packed {
        logic          busy;
        logic          rdy;
        logic [2:0]    sel;
        logic          sw;
        logic          dec;
        logic          wren;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          dp;
        logic          err;
        logic [1:0]    code;
        logic [31:0]   rc;
    } obs_t;

    typedef struct {
        logic [2:0] alg;
        logic       zoom;
        logic       clr;
        int         done_at;
        int         abort_at;
        logic [1:0] exp_code;
        int         exp_rc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy;
        o.rdy  = cmd_if.cmd_ready;
        o.sel  = eng_seletor;
        o.sw   = eng_sw;
        o.dec  = eng_decoding;
        o.wren = ram_wren;
        o.addr = ram_wraddr;
        o.data = ram_data;
        o.dp   = done_pulse;
        o.err  = error;
        o.code = err_code;
        o.rc   = run_cycles;
        return o;
    endfunction

    function automatic obs_t mk(
        logic b, logic r, logic [2:0] s, logic w, logic d, logic we,
        logic [AW-1:0] a, logic [7:0] dt, logic p, logic e,
        logic [1:0] c, logic [31:0] rc);
        obs_t o;
        o.busy = b;  o.rdy = r;  o.sel = s;   o.sw = w;
        o.dec  = d;  o.wren = we; o.addr = a; o.data = dt;
        o.dp   = p;  o.err = e;  o.code = c;  o.rc = rc;
        return o;
    endfunction

    task automatic check(input string nm, input int t, input obs_t exp);
        obs_t a;
        a = sample();
        n_cmp++;
        if (a !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] got,
                             input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic rand_eng_bus();
        eng_ram_wraddr = AW'($urandom);
        eng_ram_data   = 8'($urandom);
        eng_ram_wren   = 1'($urandom);
    endtask

    // Issues one command and checks every cycle against a timeline derived
    // from the command: t counts cycles after the accepting edge.
    task automatic do_cmd(input logic [2:0] alg, input logic zoom,
                          input logic clr, input int done_at,
                          input int abort_at, output logic [1:0] m_code,
                          output int m_rc);
        int   c_len;
        int   t;
        int   k;
        int   nxt;
        bit   legal;
        bit   fin;
        bit   in_run;
        obs_t e;

        legal  = (alg >= 3'd1) && (alg <= 3'd4);
        c_len  = clr ? FP : 0;
        m_code = 2'd0;
        m_rc   = 0;
        nxt    = 0;

        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_alg   = alg;
        cmd_if.cmd_zoom  = zoom;
        cmd_if.cmd_clear = clr;
        abort            = 1'b0;
        eng_done         = 1'($urandom);
        rand_eng_bus();
        @(negedge clk);
        check_val("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);

        if (!legal) begin
            nxt    = 2;
            m_code = 2'd1;
        end else begin
            t   = 0;
            fin = 0;
            while (!fin) begin
                #1;
                // Garbage offered while busy must be ignored.
                cmd_if.cmd_valid = 1'($urandom);
                cmd_if.cmd_alg   = 3'($urandom);
                cmd_if.cmd_zoom  = 1'($urandom);
                cmd_if.cmd_clear = 1'($urandom);
                abort            = (t == abort_at);
                rand_eng_bus();
                in_run = (t > c_len + ST);
                k      = t - c_len - ST;
                eng_done = in_run ? (k == done_at) : 1'($urandom);
                if (t < c_len)
                    e = mk(1, 0, 0, 0, 0, 1, AW'(t), 8'h00, 0, 0, 0, 0);
                else if (t == c_len)
                    e = mk(1, 0, 0, 0, 0, 0, '0, 8'h00, 0, 0, 0, 0);
                else if (!in_run)
                    e = mk(1, 0, alg, zoom, 0, 0, '0, 8'h00, 0, 0, 0, 0);
                else
                    e = mk(1, 0, alg, zoom, 1, eng_ram_wren,
                           eng_ram_wraddr, eng_ram_data, 0, 0, 0, 0);
                @(negedge clk);
                check(in_run ? "run" : "pre_run", t, e);
                if (t == abort_at) begin
                    fin = 1;
                    nxt = 0;
                end else if (in_run && k == done_at) begin
                    fin  = 1;
                    nxt  = 1;
                    m_rc = k;
                end else if (in_run && k == TO) begin
                    fin    = 1;
                    nxt    = 2;
                    m_code = 2'd2;
                    m_rc   = k;
                end
                t++;
                @(posedge clk);
            end
        end

        for (int p = 0; p < 2; p++) begin
            #1;
            cmd_if.cmd_valid = 1'b0;
            abort            = 1'($urandom);
            eng_done         = 1'($urandom);
            rand_eng_bus();
            if (nxt == 0)
                e = mk(0, 1, 0, 0, 0, 0, '0, 8'h00, 0, 0, 0, 0);
            else if (nxt == 1)
                e = mk(0, 1, alg, zoom, 0, 0, '0, 8'h00,
                       (p == 0), 0, 0, 32'(m_rc));
            else
                e = mk(0, 1, 0, 0, 0, 0, '0, 8'h00, 0, 1, m_code,
                       32'(m_rc));
            @(negedge clk);
            check("post", p, e);
            @(posedge clk);
        end
    endtask

    vec_t       vt[12];
    logic [1:0] mc;
    int         mr;
    obs_t       idle_o;

    initial begin
        // {alg, zoom, clr, done_at, abort_at, exp_code, exp_rc}
        vt[0]  = '{3'd1, 1'b0, 1'b0, 500, -1, 2'd0, 500};
        vt[1]  = '{3'd1, 1'b0, 1'b0, 500, -1, 2'd0, 500};
        vt[2]  = '{3'd3, 1'b1, 1'b1, 20,  -1, 2'd0, 20};
        vt[3]  = '{3'd6, 1'b0, 1'b0, 5,   -1, 2'd1, 0};
        vt[4]  = '{3'd2, 1'b0, 1'b0, 0,   -1, 2'd2, TO};
        vt[5]  = '{3'd3, 1'b0, 1'b1, 10,  7,  2'd0, 0};
        vt[6]  = '{3'd4, 1'b1, 1'b0, 5,   7,  2'd0, 0};
        vt[7]  = '{3'd0, 1'b1, 1'b1, 5,   -1, 2'd1, 0};
        vt[8]  = '{3'd4, 1'b1, 1'b0, 1,   -1, 2'd0, 1};
        vt[9]  = '{3'd2, 1'b1, 1'b0, TO,  -1, 2'd0, TO};
        vt[10] = '{3'd1, 1'b1, 1'b0, 9,   0,  2'd0, 0};
        vt[11] = '{3'd2, 1'b0, 1'b0, 9,   1,  2'd0, 0};

        idle_o = mk(0, 1, 0, 0, 0, 0, '0, 8'h00, 0, 0, 0, 0);

        reset            = 1'b1;
        abort            = 1'b0;
        eng_done         = 1'b0;
        eng_ram_wraddr   = '0;
        eng_ram_data     = 8'h00;
        eng_ram_wren     = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_alg   = 3'd0;
        cmd_if.cmd_zoom  = 1'b0;
        cmd_if.cmd_clear = 1'b0;

        repeat (2) @(negedge clk);
        check("in_reset", 0, idle_o);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset", 0, idle_o);

        // Abort while idle does nothing.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            abort = 1'b1;
            @(negedge clk);
            check("abort_idle", i, idle_o);
        end
        abort = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_cmd(vt[i].alg, vt[i].zoom, vt[i].clr, vt[i].done_at,
                   vt[i].abort_at, mc, mr);
            check_val($sformatf("vec%0d_code", i), 32'(err_code),
                      32'(vt[i].exp_code));
            check_val($sformatf("vec%0d_rc", i), run_cycles,
                      32'(vt[i].exp_rc));
        end

        for (int i = 0; i < 25; i++) begin
            logic [2:0] ra;
            logic       rz;
            logic       rcl;
            int         rd;
            int         rab;
            ra  = 3'($urandom_range(0, 7));
            rz  = 1'($urandom);
            rcl = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0) ? 0 :
                  int'($urandom_range(1, 40));
            rab = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(0, 40)) : -1;
            do_cmd(ra, rz, rcl, rd, rab, mc, mr);
        end

        // Asynchronous reset in the middle of a clear.
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_alg   = 3'd1;
        cmd_if.cmd_zoom  = 1'b1;
        cmd_if.cmd_clear = 1'b1;
        abort            = 1'b0;
        eng_done         = 1'b0;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("clear_before_reset", 0,
              mk(1, 0, 0, 0, 0, 1, AW'(2), 8'h00, 0, 0, 0, 0));
        reset = 1'b1;
        #1;
        check("async_reset", 0, idle_o);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after_async_reset", 0, idle_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
